// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-addressed instructions to an external
// combinational 4-bit ALU and writes the result back to a small register file.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_valid/instr_ready   instruction handshake (ready only in IDLE)
//   instr_op/rd/rs1/rs2       opcode, destination and source registers
//   wr_en/wr_addr/wr_data     direct register preload (honoured in IDLE only)
//   rd_addr/rd_data           combinational register readback
//   alu_a/alu_b/alu_op        registered operands and opcode to the ALU
//   alu_res/alu_flag          ALU result and {zero,carry}
//   res_out/flag_out          last captured result and flags
//   done                      one-cycle writeback pulse
//   busy                      high in ISSUE and CAPTURE
//   clr_flags/flags_sticky    sticky {zero,carry} accumulator
//
// Optional feature macro: ALU_STICKY_FLAGS_EN (sticky flags; tied to 0 when
// undefined, and clr_flags is then ignored).

module alu_issue_ctrl #(
    parameter int WIDTH = 4,
    parameter int NREGS = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs1,
    input  logic [AW-1:0]    instr_rs2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic [1:0]       alu_flag,
    output logic [WIDTH-1:0] res_out,
    output logic [1:0]       flag_out,
    output logic             done,
    output logic             busy,
    input  logic             clr_flags,
    output logic [1:0]       flags_sticky
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] regs [NREGS];
    logic [AW-1:0]    rd_q;

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state == S_ISSUE) || (state == S_CAPTURE);
    assign rd_data     = regs[rd_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            state    <= S_IDLE;
            rd_q     <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            res_out  <= '0;
            flag_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Operand reads below use the pre-write register values,
                    // so a same-cycle preload to a source is not forwarded.
                    if (wr_en) begin
                        regs[wr_addr] <= wr_data;
                    end
                    if (instr_valid) begin
                        alu_a  <= regs[instr_rs1];
                        alu_b  <= regs[instr_rs2];
                        alu_op <= instr_op;
                        rd_q   <= instr_rd;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Operands held one full cycle so the ALU settles.
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    regs[rd_q] <= alu_res;
                    res_out    <= alu_res;
                    flag_out   <= alu_flag;
                    done       <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    // Clear takes effect first, so a coincident writeback leaves its flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_sticky <= '0;
        end else if (state == S_CAPTURE) begin
            flags_sticky <= (clr_flags ? 2'b00 : flags_sticky) | alu_flag;
        end else if (clr_flags) begin
            flags_sticky <= '0;
        end
    end
`else
    logic unused_clr_flags;
    assign unused_clr_flags = clr_flags;
    assign flags_sticky     = '0;
`endif

endmodule
